// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the multiply/divide unit
package mdu_pkg;
    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mdu_state_t;
endpackage

// File: rtl/mdu_addsub.sv
// rtl/mdu_addsub.sv - WIDTH+1-bit adder/subtractor shared by multiply and divide steps
module mdu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] x,
    input  logic [WIDTH:0] y,
    input  logic           sub,
    output logic [WIDTH:0] res
);
    assign res = sub ? (x - y) : (x + y);
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/DIV sequencer owning the HI/LO register pair
import mdu_pkg::*;

module muldiv_unit #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = (WIDTH == MDU_WIDTH) ? MDU_CNT_W : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             is_div, neg_q, neg_r;

    logic             md_op, signed_op, div_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   as_x, as_y, as_res;
    logic             trial_ok;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign md_op     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign div_op    = (op == OP_DIV) || (op == OP_DIVU);
    assign a_neg     = signed_op && a[WIDTH-1];
    assign b_neg     = signed_op && b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;

    // Divide shifts the next dividend bit into the partial remainder before the trial subtract.
    assign as_x = is_div ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
    assign as_y = {1'b0, opnd};
    assign trial_ok = ~as_res[WIDTH];

    mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x   (as_x),
        .y   (as_y),
        .sub (is_div),
        .res (as_res)
    );

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
    // A zero divisor leaves an all-ones quotient regardless of operand signs.
    assign quo_fix  = (neg_q && (opnd != '0)) ? (~acc_lo + 1'b1) : acc_lo;
    assign rem_fix  = neg_r ? (~acc_hi + 1'b1) : acc_hi;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort && md_op) state_nxt = RUN;
            RUN:     if (abort) state_nxt = IDLE;
                     else if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start && !abort) begin
                    if (md_op) begin
                        cnt    <= '0;
                        is_div <= div_op;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        acc_hi <= '0;
                        acc_lo <= div_op ? a_mag : b_mag;
                        opnd   <= div_op ? b_mag : a_mag;
                    end else if (op == OP_MTHI) begin
                        hi <= a;
                    end else if (op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                RUN: if (!abort) begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc_hi <= trial_ok ? as_res[WIDTH-1:0] : as_x[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], trial_ok};
                    end else if (acc_lo[0]) begin
                        {acc_hi, acc_lo} <= {as_res, acc_lo[WIDTH-1:1]};
                    end else begin
                        {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: if (!abort) begin
                    done <= 1'b1;
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_e;
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} from plain arithmetic on the architectural operands.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        int sx, sy;
        logic [63:0] r;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin
                p = longint'(sx) * longint'(sy);
                r = 64'(p);
            end
            3'd1: r = {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, x};
                else r = {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hilo", {hi, lo}, mon_e);
                check("busy_at_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int n;
        logic [63:0] r;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        if (o < 3'd4) begin
            r = model(o, x, y);
            exp_q.push_back(r);
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (o < 3'd4) begin
            check("busy_after_accept", {63'd0, busy}, 64'd1);
            n = 0;
            while (!done && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check("done_latency", 64'(n), 64'(W + 1));
            {m_hi, m_lo} = r;
        end else begin
            if (o == 3'd4) m_hi = x;
            if (o == 3'd5) m_lo = x;
            check("mtxx_busy", {62'd0, busy, done}, 64'd0);
        end
        check("hi_arch", 64'(hi), 64'(m_hi));
        check("lo_arch", 64'(lo), 64'(m_lo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        logic [2:0] o;
        logic [31:0] x, y;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk) reset_n = 1'b1;

        // Reset mid-run at counter 10
        run_op(3'd4, 32'h1111_2222, 0);
        run_op(3'd5, 32'h3333_4444, 0);
        @(posedge clk); #1;
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_hilo", {hi, lo}, 64'd0);
        check("async_reset_busy", {62'd0, busy, done}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk) reset_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd3, 32'd100, 32'd7);
        run_op(3'd2, 32'h1234, 32'd0);
        run_op(3'd2, 32'hFFFF_1234, 32'd0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'hDEAD_BEEF, 32'd1);

        // MTHI, then DIVU with a re-pulsed start and an abort mid-run
        run_op(3'd4, 32'h0000_ABCD, 0);
        dc = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1; op = 3'd5; a = 32'h5555;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_run_busy", {63'd0, busy}, 64'd0);
        check("abort_run_hilo", {hi, lo}, {m_hi, m_lo});
        repeat (40) @(posedge clk);
        check("abort_run_no_done", 64'(done_cnt), 64'(dc));

        // Abort while in FIX
        @(posedge clk); #1;
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (W) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_fix_busy", {62'd0, busy, done}, 64'd0);
        check("abort_fix_hilo", {hi, lo}, {m_hi, m_lo});

        // Abort in IDLE drops a simultaneous start
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; op = 3'd4; a = 32'h9999;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_idle", {31'd0, busy, hi}, {32'd0, m_hi});

        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 5));
            x = $urandom;
            case ($urandom_range(0, 4))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
            run_op(o, x, y);
        end

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
